ptp_pdelay_mp: RTL
==================

PTP_PDELAY_MP -- requirements
Module: ptp_pdelay_mp

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of independent peer-delay channels (1..16).
REQ-002 Parameter AVG_SHIFT, default 3, exponential-average shift (0 = pass-through).
REQ-003 Parameter MAX_PDELAY_NS, default 100000, upper sanity bound on the raw delay in ns.
REQ-004 i_clk  in  1  250 MHz clock; the single clock domain.
REQ-005 i_rst  in  1  reset, asynchronous and active-high.
REQ-006 i_pdelay_t0/t1/t2/t3  in  NUM_PORTS*80 each  packed per-port timestamps, port p at [p*80+:80]; each is [79:32] seconds, [31:0] ns (<1e9).
REQ-007 i_pdelaytime_valid  in  NUM_PORTS  per-port one-cycle strobe; that port's t0..t3 are valid in the strobe cycle.
REQ-008 o_pdelay_time  out  80  filtered delay {48'd0, ns[31:0]}.
REQ-009 o_pdelay_port  out  $clog2(NUM_PORTS) (min 1)  port index the result belongs to.
REQ-010 o_pdelay_time_valid  out  1  one-cycle result strobe.
REQ-011 o_pdelay_err  out  1  qualifies o_pdelay_time_valid: sample rejected.
REQ-012 o_overrun  out  NUM_PORTS  one-cycle pulse: a pending, unprocessed sample on that port was overwritten.

Function
REQ-013 Capture: on a strobe, store that port's t0..t3 in a per-port holding register and set its pending bit; a strobe on an already-pending port overwrites the held data and pulses o_overrun[p].
REQ-014 FSM states IDLE, LOAD, SUB, NORM, FILT, OUT; every state except IDLE lasts exactly one cycle.
REQ-015 IDLE: if any pending bit is set, grant round-robin starting at the port after the last granted port (port 0 first after reset), then go to LOAD.
REQ-016 LOAD: copy the granted holding register to the datapath and clear its pending bit, unless a strobe for that port occurs in the same cycle, in which case the new data stays pending.
REQ-017 SUB: turnaround = t3 - t0 and residence = t2 - t1, each computed as secdiff*1e9 + nsdiff in 34-bit signed arithmetic.
REQ-018 NORM: raw = (turnaround - residence) >>> 1 (arithmetic shift, truncate toward minus infinity).
REQ-019 Error when: a secdiff is outside {0,1}; turnaround < 0; residence < 0; raw < 0; or raw > MAX_PDELAY_NS.
REQ-020 FILT, no error, port's first sample since reset: filt[p] = raw, and the port's init flag is set.
REQ-021 FILT, no error, later samples: filt[p] += (raw - filt[p]) >>> AVG_SHIFT, with 34-bit signed intermediates.
REQ-022 FILT, error: filt[p] and the init flag are left unchanged.
REQ-023 OUT: assert o_pdelay_time_valid for one cycle with o_pdelay_port = granted port, o_pdelay_time = {48'd0, filt[p][31:0]} (0 if the port has never been initialised), and o_pdelay_err as determined; then go to IDLE.
REQ-024 Latency with the FSM idle: a strobe in cycle N gives o_pdelay_time_valid in cycle N+6; throughput is one result per 6 cycles.
REQ-025 Outputs hold their last values between strobes, except the valid and err strobes, which are 0.

Reset
REQ-026 Async assertion clears: pending bits, holding registers, init flags, filt[], round-robin pointer (to port 0), FSM (to IDLE), and all outputs (to 0).
REQ-027 Reset mid-computation discards the in-flight sample with no output strobe.
REQ-028 Reset is released synchronously to i_clk.

Structure
REQ-029 Shared PTP package holds: TS_W=80, SEC_W=48, NS_W=32, NS_PER_SEC=1000000000, and the FSM state encoding.
REQ-030 The round-robin arbiter is a sub-module, ptp_rr_arbiter (request vector in, one-hot grant out, pointer update on accept).

Verification
REQ-031 Basic: port0 t0={10s,100}, t1={20s,500}, t2={20s,1500}, t3={10s,3100} -> cycle N+6: valid=1, err=0, port=0, time=1000.
REQ-032 Second wrap: t0={5s,999999000}, t3={6s,2000}, t1=t2={7s,0} -> raw=1500, err=0.
REQ-033 Filter: port1 raws 1000 then 1800, AVG_SHIFT=3 -> outputs 1000 then 1100.
REQ-034 Errors: residence negative (t2<t1), or raw=200000 -> err=1, time holds the prior filtered value, filter unchanged.
REQ-035 Contention: strobes on all 4 ports in the same cycle -> four results ordered ports 0,1,2,3, spaced 6 cycles; a repeat strobe on port 3 before it is granted -> o_overrun[3]=1 and the newer data is used.
REQ-036 Reset asserted during SUB -> no strobe; all outputs 0; the next sample on that port re-initialises the filter (output = raw).

Source files
------------

// File: rtl/ptp_pdelay_mp_pkg.sv
// Shared PTP definitions: timestamp layout, time constants and the peer-delay FSM encoding.
package ptp_pdelay_mp_pkg;

    localparam int TS_W  = 80;
    localparam int SEC_W = 48;
    localparam int NS_W  = 32;
    localparam int unsigned NS_PER_SEC = 32'd1000000000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SUB  = 3'd2,
        ST_NORM = 3'd3,
        ST_FILT = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    typedef struct packed {
        logic [SEC_W-1:0] sec;
        logic [NS_W-1:0]  ns;
    } ts_t;

    typedef struct packed {
        ts_t t0;
        ts_t t1;
        ts_t t2;
        ts_t t3;
    } ts_set_t;

    // A seconds difference is usable only when it is 0 or 1.
    function automatic logic sec_ok(input logic [SEC_W-1:0] d);
        return d[SEC_W-1:1] == '0;
    endfunction

endpackage

// File: rtl/ptp_pdelay_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the port after the last accepted grant.
// Pointer starts at port 0 and only advances when the grant is accepted.
module ptp_rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_accept,
    output logic [N-1:0] o_gnt
);

    logic [PW-1:0] nxt_q, nxt_d;
    logic          found;
    int            idx;

    always_comb begin
        o_gnt = '0;
        found = 1'b0;
        nxt_d = nxt_q;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(nxt_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                found      = 1'b1;
                if (i_accept) nxt_d = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) nxt_q <= '0;
        else       nxt_q <= nxt_d;
    end

endmodule

// File: rtl/ptp_pdelay_mp.sv
// Multi-port peer-delay calculator: per-port capture, round-robin service, shared
// sequential datapath (LOAD/SUB/NORM/FILT/OUT) with a per-port exponential filter.
module ptp_pdelay_mp
    import ptp_pdelay_mp_pkg::*;
#(
    parameter  int NUM_PORTS     = 4,
    parameter  int AVG_SHIFT     = 3,
    parameter  int MAX_PDELAY_NS = 100000,
    localparam int PW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_PORTS*TS_W-1:0] i_pdelay_t0,
    input  logic [NUM_PORTS*TS_W-1:0] i_pdelay_t1,
    input  logic [NUM_PORTS*TS_W-1:0] i_pdelay_t2,
    input  logic [NUM_PORTS*TS_W-1:0] i_pdelay_t3,
    input  logic [NUM_PORTS-1:0]      i_pdelaytime_valid,
    output logic [TS_W-1:0]           o_pdelay_time,
    output logic [PW-1:0]             o_pdelay_port,
    output logic                      o_pdelay_time_valid,
    output logic                      o_pdelay_err,
    output logic [NUM_PORTS-1:0]      o_overrun
);

    localparam logic signed [33:0] NS_S  = 34'(NS_PER_SEC);
    localparam logic signed [33:0] MAX_S = 34'(MAX_PDELAY_NS);

    state_t                   state_q, state_d;
    logic [NUM_PORTS-1:0]     pend_q, pend_d;
    ts_set_t                  hold_q [NUM_PORTS];
    ts_set_t                  hold_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]     init_q, init_d;
    logic signed [33:0]       filt_q [NUM_PORTS];
    logic signed [33:0]       filt_d [NUM_PORTS];
    logic [PW-1:0]            sel_q, sel_d;
    ts_set_t                  dp_q, dp_d;
    logic signed [33:0]       turn_q, turn_d, res_q, res_d, raw_q, raw_d;
    logic                     serr_q, serr_d, err_q, err_d;
    logic [TS_W-1:0]          time_q, time_d;
    logic [PW-1:0]            port_q, port_d;
    logic                     valid_q, valid_d, oerr_q, oerr_d;
    logic [NUM_PORTS-1:0]     ovr_q, ovr_d;

    logic [NUM_PORTS-1:0]     gnt;
    logic [PW-1:0]            gidx;
    logic                     accept;

    logic [SEC_W-1:0]         sec_turn, sec_res;
    logic signed [33:0]       ns_turn, ns_res, turn_c, res_c, raw_c;
    logic signed [33:0]       flt_cur, flt_step, flt_new;
    logic                     err_c;

    assign accept = (state_q == ST_IDLE) && (|pend_q);

    ptp_rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (pend_q),
        .i_accept (accept),
        .o_gnt    (gnt)
    );

    always_comb begin
        gidx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) gidx = PW'(p);
        end
    end

    // Intervals are secdiff*1e9 + nsdiff; secdiff outside {0,1} is flagged separately.
    assign sec_turn = dp_q.t3.sec - dp_q.t0.sec;
    assign sec_res  = dp_q.t2.sec - dp_q.t1.sec;
    assign ns_turn  = $signed({2'b00, dp_q.t3.ns}) - $signed({2'b00, dp_q.t0.ns});
    assign ns_res   = $signed({2'b00, dp_q.t2.ns}) - $signed({2'b00, dp_q.t1.ns});
    assign turn_c   = ((sec_turn == SEC_W'(1)) ? NS_S : 34'sd0) + ns_turn;
    assign res_c    = ((sec_res  == SEC_W'(1)) ? NS_S : 34'sd0) + ns_res;

    assign raw_c = (turn_q - res_q) >>> 1;
    assign err_c = serr_q || (turn_q < 0) || (res_q < 0) || (raw_c < 0) || (raw_c > MAX_S);

    assign flt_cur  = filt_q[sel_q];
    assign flt_step = (raw_q - flt_cur) >>> AVG_SHIFT;
    assign flt_new  = init_q[sel_q] ? (flt_cur + flt_step) : raw_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        init_d  = init_q;
        filt_d  = filt_q;
        sel_d   = sel_q;
        dp_d    = dp_q;
        turn_d  = turn_q;
        res_d   = res_q;
        raw_d   = raw_q;
        serr_d  = serr_q;
        err_d   = err_q;
        time_d  = time_q;
        port_d  = port_q;
        valid_d = 1'b0;
        oerr_d  = 1'b0;
        ovr_d   = '0;

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (i_pdelaytime_valid[p]) begin
                hold_d[p].t0 = i_pdelay_t0[p*TS_W +: TS_W];
                hold_d[p].t1 = i_pdelay_t1[p*TS_W +: TS_W];
                hold_d[p].t2 = i_pdelay_t2[p*TS_W +: TS_W];
                hold_d[p].t3 = i_pdelay_t3[p*TS_W +: TS_W];
                pend_d[p]    = 1'b1;
                // Data being copied out this very cycle is consumed, not lost.
                ovr_d[p]     = pend_q[p] && !((state_q == ST_LOAD) && (sel_q == PW'(p)));
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    sel_d   = gidx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dp_d = hold_q[sel_q];
                if (!i_pdelaytime_valid[sel_q]) pend_d[sel_q] = 1'b0;
                state_d = ST_SUB;
            end
            ST_SUB: begin
                turn_d  = turn_c;
                res_d   = res_c;
                serr_d  = !(sec_ok(sec_turn) && sec_ok(sec_res));
                state_d = ST_NORM;
            end
            ST_NORM: begin
                raw_d   = raw_c;
                err_d   = err_c;
                state_d = ST_FILT;
            end
            ST_FILT: begin
                if (!err_q) begin
                    filt_d[sel_q] = flt_new;
                    init_d[sel_q] = 1'b1;
                    time_d        = {48'd0, flt_new[31:0]};
                end else begin
                    time_d        = {48'd0, flt_cur[31:0]};
                end
                port_d  = sel_q;
                valid_d = 1'b1;
                oerr_d  = err_q;
                state_d = ST_OUT;
            end
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            init_q  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                hold_q[p] <= '0;
                filt_q[p] <= '0;
            end
            sel_q   <= '0;
            dp_q    <= '0;
            turn_q  <= '0;
            res_q   <= '0;
            raw_q   <= '0;
            serr_q  <= 1'b0;
            err_q   <= 1'b0;
            time_q  <= '0;
            port_q  <= '0;
            valid_q <= 1'b0;
            oerr_q  <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            init_q  <= init_d;
            hold_q  <= hold_d;
            filt_q  <= filt_d;
            sel_q   <= sel_d;
            dp_q    <= dp_d;
            turn_q  <= turn_d;
            res_q   <= res_d;
            raw_q   <= raw_d;
            serr_q  <= serr_d;
            err_q   <= err_d;
            time_q  <= time_d;
            port_q  <= port_d;
            valid_q <= valid_d;
            oerr_q  <= oerr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_pdelay_time       = time_q;
    assign o_pdelay_port       = port_q;
    assign o_pdelay_time_valid = valid_q;
    assign o_pdelay_err        = oerr_q;
    assign o_overrun           = ovr_q;

endmodule
